// File: rtl/llc_mem_req_queue.sv
// rtl/llc_mem_req_queue.sv - LLC memory request FIFO with read cap, response skid and drain handshake
module llc_mem_req_queue #(
  parameter int DEPTH           = 4,
  parameter int ADDR_W          = 32,
  parameter int LINE_W          = 128,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req_valid,
  output logic              core_req_ready,
  input  logic              core_req_hwrite,
  input  logic [2:0]        core_req_hsize,
  input  logic [1:0]        core_req_hprot,
  input  logic [ADDR_W-1:0] core_req_addr,
  input  logic [LINE_W-1:0] core_req_line,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_hwrite,
  output logic [2:0]        mem_req_hsize,
  output logic [1:0]        mem_req_hprot,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [LINE_W-1:0] mem_req_line,
  input  logic              mem_rsp_valid,
  output logic              mem_rsp_ready,
  input  logic [LINE_W-1:0] mem_rsp_line,
  output logic              core_rsp_valid,
  input  logic              core_rsp_ready,
  output logic [LINE_W-1:0] core_rsp_line,
  input  logic              drain_req,
  output logic              drain_done,
  output logic [3:0]        outstanding,
  output logic              err_unexpected_rsp
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic              hwrite;
    logic [2:0]        hsize;
    logic [1:0]        hprot;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] line;
  } req_t;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  req_t              fifo_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [3:0]        outst_q, outst_d;
  logic              skid_valid_q, skid_valid_d;
  logic [LINE_W-1:0] skid_line_q, skid_line_d;
  logic              err_q, err_d;
  state_t            state_q, state_d;

  logic full, empty, push, pop, rd_issue, rsp_hs;
  req_t head;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  // Head is zeroed when empty so stale storage never shows on the memory port.
  assign head  = empty ? '0 : fifo_q[rd_ptr_q];

  assign core_req_ready = !full && (state_q == RUN);
  assign mem_req_valid  = !empty && (head.hwrite || (outst_q < 4'(MAX_OUTSTANDING)));
  assign push     = core_req_valid && core_req_ready;
  assign pop      = mem_req_valid && mem_req_ready;
  assign rd_issue = pop && !head.hwrite;

  assign mem_req_hwrite = head.hwrite;
  assign mem_req_hsize  = head.hsize;
  assign mem_req_hprot  = head.hprot;
  assign mem_req_addr   = head.addr;
  assign mem_req_line   = head.line;

  assign mem_rsp_ready      = !skid_valid_q || core_rsp_ready;
  assign rsp_hs             = mem_rsp_valid && mem_rsp_ready;
  assign core_rsp_valid     = skid_valid_q;
  assign core_rsp_line      = skid_line_q;
  assign drain_done         = (state_q == DONE);
  assign outstanding        = outst_q;
  assign err_unexpected_rsp = err_q;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {core_req_hwrite, core_req_hsize, core_req_hprot,
                                   core_req_addr, core_req_line};
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    outst_d      = outst_q;
    err_d        = err_q;
    skid_valid_d = skid_valid_q;
    skid_line_d  = skid_line_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop) count_d = count_q + CNT_W'(1);
    if (!push && pop) count_d = count_q - CNT_W'(1);
    // Counter saturates at zero; a response with nothing outstanding only flags the error.
    if (rd_issue && !rsp_hs) outst_d = outst_q + 4'd1;
    else if (!rd_issue && rsp_hs && (outst_q != 4'd0)) outst_d = outst_q - 4'd1;
    if (rsp_hs && (outst_q == 4'd0)) err_d = 1'b1;
    if (rsp_hs) begin
      skid_valid_d = 1'b1;
      skid_line_d  = mem_rsp_line;
    end else if (core_rsp_ready) begin
      skid_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:   if (drain_req) state_d = DRAIN;
      DRAIN: begin
        if (!drain_req) state_d = RUN;
        else if (empty && (outst_q == 4'd0) && !skid_valid_q) state_d = DONE;
      end
      DONE:  if (!drain_req) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      outst_q      <= '0;
      err_q        <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_line_q  <= '0;
      state_q      <= RUN;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      outst_q      <= outst_d;
      err_q        <= err_d;
      skid_valid_q <= skid_valid_d;
      skid_line_q  <= skid_line_d;
      state_q      <= state_d;
    end
  end

endmodule

// File: tb/tb_llc_mem_req_queue.sv
// tb/tb_llc_mem_req_queue.sv - directed scoreboard bench for llc_mem_req_queue
module tb_llc_mem_req_queue;
    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int REQ_W  = 1 + 3 + 2 + ADDR_W + LINE_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_req_valid, core_req_ready, core_req_hwrite;
    logic [2:0]        core_req_hsize;
    logic [1:0]        core_req_hprot;
    logic [ADDR_W-1:0] core_req_addr;
    logic [LINE_W-1:0] core_req_line;
    logic              mem_req_valid, mem_req_ready, mem_req_hwrite;
    logic [2:0]        mem_req_hsize;
    logic [1:0]        mem_req_hprot;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_req_line;
    logic              mem_rsp_valid, mem_rsp_ready;
    logic [LINE_W-1:0] mem_rsp_line;
    logic              core_rsp_valid, core_rsp_ready;
    logic [LINE_W-1:0] core_rsp_line;
    logic              drain_req, drain_done, err_unexpected_rsp;
    logic [3:0]        outstanding;

    int n_tests = 0;
    int n_fail  = 0;
    logic [REQ_W-1:0]  exp_req_q [$];
    logic [LINE_W-1:0] exp_rsp_q [$];
    logic [REQ_W-1:0]  exp_req;
    logic [LINE_W-1:0] exp_rsp;

    always #5 clk = ~clk;

    llc_mem_req_queue dut (
        .clk(clk), .rst(rst),
        .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
        .core_req_hwrite(core_req_hwrite), .core_req_hsize(core_req_hsize),
        .core_req_hprot(core_req_hprot), .core_req_addr(core_req_addr),
        .core_req_line(core_req_line),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_hwrite(mem_req_hwrite), .mem_req_hsize(mem_req_hsize),
        .mem_req_hprot(mem_req_hprot), .mem_req_addr(mem_req_addr),
        .mem_req_line(mem_req_line),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
        .mem_rsp_line(mem_rsp_line),
        .core_rsp_valid(core_rsp_valid), .core_rsp_ready(core_rsp_ready),
        .core_rsp_line(core_rsp_line),
        .drain_req(drain_req), .drain_done(drain_done),
        .outstanding(outstanding), .err_unexpected_rsp(err_unexpected_rsp)
    );

    task automatic chk(input string tag, input bit ok);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $error("FAIL %s", tag);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && mem_req_valid && mem_req_ready) begin
            if (exp_req_q.size() == 0) begin
                chk("mem_req_extra", mem_req_valid === 1'b0);
            end else begin
                exp_req = exp_req_q.pop_front();
                chk("mem_req_order", {mem_req_hwrite, mem_req_hsize, mem_req_hprot, mem_req_addr, mem_req_line} === exp_req);
            end
        end
        if (!rst && core_rsp_valid && core_rsp_ready) begin
            if (exp_rsp_q.size() == 0) begin
                chk("core_rsp_extra", core_rsp_valid === 1'b0);
            end else begin
                exp_rsp = exp_rsp_q.pop_front();
                chk("core_rsp_order", core_rsp_line === exp_rsp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic hw, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] l);
        chk("push_ready", core_req_ready === 1'b1);
        core_req_valid  = 1'b1;
        core_req_hwrite = hw;
        core_req_hsize  = 3'd4;
        core_req_hprot  = hw ? 2'b11 : 2'b01;
        core_req_addr   = a;
        core_req_line   = l;
        exp_req_q.push_back({hw, 3'd4, (hw ? 2'b11 : 2'b01), a, l});
        step();
        core_req_valid = 1'b0;
    endtask

    task automatic send_rsp(input logic [LINE_W-1:0] l);
        mem_rsp_valid = 1'b1;
        mem_rsp_line  = l;
        exp_rsp_q.push_back(l);
        step();
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        core_req_valid = 0; core_req_hwrite = 0; core_req_hsize = 0; core_req_hprot = 0;
        core_req_addr = 0; core_req_line = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_line = 0;
        core_rsp_ready = 1; drain_req = 0;
        step(); step();
        chk("rst_core_req_ready", core_req_ready === 1'b1);
        chk("rst_mem_req_valid", mem_req_valid === 1'b0);
        chk("rst_mem_rsp_ready", mem_rsp_ready === 1'b1);
        chk("rst_core_rsp_valid", core_rsp_valid === 1'b0);
        chk("rst_drain_done", drain_done === 1'b0);
        chk("rst_outstanding", outstanding === 4'd0);
        chk("rst_err", err_unexpected_rsp === 1'b0);
        chk("rst_mem_req_addr", mem_req_addr === 32'h0);
        chk("rst_core_rsp_line", core_rsp_line === 128'h0);
        rst = 1'b0;
        step();

        push(1'b0, 32'h100, 128'h0);
        chk("latency_valid", mem_req_valid === 1'b1);
        push(1'b0, 32'h140, 128'h0);
        push(1'b0, 32'h180, 128'h0);
        push(1'b0, 32'h1C0, 128'h0);
        chk("full_ready_low", core_req_ready === 1'b0);
        chk("full_head_addr", mem_req_addr === 32'h100);
        mem_req_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("outst_ramp", outstanding === 4'(i));
        end
        chk("drained_valid_low", mem_req_valid === 1'b0);

        push(1'b0, 32'h300, 128'h0);
        chk("cap_stall", mem_req_valid === 1'b0);
        chk("cap_outst", outstanding === 4'd4);
        send_rsp({16{8'hA5}});
        chk("cap_outst_dec", outstanding === 4'd3);
        chk("cap_rsp_line", core_rsp_line === {16{8'hA5}});
        chk("cap_issue_valid", mem_req_valid === 1'b1);
        step();
        chk("cap_outst_back", outstanding === 4'd4);
        chk("cap_valid_low", mem_req_valid === 1'b0);
        chk("cap_skid_empty", core_rsp_valid === 1'b0);

        mem_req_ready = 1'b0;
        push(1'b1, 32'h200, 128'h1234);
        chk("wr_valid", mem_req_valid === 1'b1);
        chk("wr_hwrite", mem_req_hwrite === 1'b1);
        chk("wr_addr", mem_req_addr === 32'h200);
        mem_req_ready = 1'b1;
        step();
        chk("wr_outst_same", outstanding === 4'd4);

        core_rsp_ready = 1'b0;
        send_rsp({4{32'h11111111}});
        mem_rsp_valid = 1'b1;
        mem_rsp_line  = {4{32'h22222222}};
        exp_rsp_q.push_back({4{32'h22222222}});
        #1;
        chk("skid_block", mem_rsp_ready === 1'b0);
        step();
        chk("skid_hold_line", core_rsp_line === {4{32'h11111111}});
        chk("skid_outst", outstanding === 4'd3);
        core_rsp_ready = 1'b1;
        #1;
        chk("skid_unblock", mem_rsp_ready === 1'b1);
        step();
        mem_rsp_valid = 1'b0;
        chk("skid_second_valid", core_rsp_valid === 1'b1);
        chk("skid_second_line", core_rsp_line === {4{32'h22222222}});
        step();
        chk("skid_empty", core_rsp_valid === 1'b0);
        send_rsp(128'h3);
        send_rsp(128'h4);
        step();
        chk("outst_zero", outstanding === 4'd0);

        mem_req_ready = 1'b0;
        push(1'b0, 32'h400, 128'h0);
        push(1'b0, 32'h440, 128'h0);
        drain_req = 1'b1;
        step();
        chk("drain_ready_low", core_req_ready === 1'b0);
        mem_req_ready = 1'b1;
        step(); step();
        chk("drain_outst", outstanding === 4'd2);
        chk("drain_not_done", drain_done === 1'b0);
        send_rsp(128'h5);
        send_rsp(128'h6);
        for (int i = 0; i < 10 && !drain_done; i++) step();
        chk("drain_done", drain_done === 1'b1);
        chk("done_ready_low", core_req_ready === 1'b0);
        drain_req = 1'b0;
        step();
        chk("undrain_done_low", drain_done === 1'b0);
        chk("undrain_ready", core_req_ready === 1'b1);

        mem_req_ready = 1'b0;
        push(1'b0, 32'h500, 128'h0);
        drain_req = 1'b1;
        step();
        chk("abort_ready_low", core_req_ready === 1'b0);
        drain_req = 1'b0;
        step();
        chk("abort_no_done", drain_done === 1'b0);
        chk("abort_ready", core_req_ready === 1'b1);
        mem_req_ready = 1'b1;
        step();
        send_rsp(128'h7);
        step();

        core_rsp_ready = 1'b0;
        mem_req_ready  = 1'b0;
        send_rsp(128'hDEAD);
        chk("unexp_err", err_unexpected_rsp === 1'b1);
        chk("unexp_outst", outstanding === 4'd0);
        chk("unexp_forward", core_rsp_line === 128'hDEAD);
        push(1'b0, 32'h600, 128'h0);
        push(1'b1, 32'h640, 128'h99);
        push(1'b0, 32'h680, 128'h0);
        chk("pre_rst_valid", mem_req_valid === 1'b1);
        rst = 1'b1;
        #1;
        exp_req_q.delete();
        exp_rsp_q.delete();
        chk("mid_rst_mem_req_valid", mem_req_valid === 1'b0);
        chk("mid_rst_core_req_ready", core_req_ready === 1'b1);
        chk("mid_rst_err", err_unexpected_rsp === 1'b0);
        chk("mid_rst_core_rsp_valid", core_rsp_valid === 1'b0);
        chk("mid_rst_core_rsp_line", core_rsp_line === 128'h0);
        chk("mid_rst_addr", mem_req_addr === 32'h0);
        step();
        rst = 1'b0;
        core_rsp_ready = 1'b1;
        step();
        chk("post_rst_empty", mem_req_valid === 1'b0);
        chk("post_rst_ready", core_req_ready === 1'b1);
        chk("post_rst_outst", outstanding === 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
